mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified 16-bit memory port between two requesters: the multi-cycle processor (Control-driven MemR/MemW path) and the debug/boot-load port.
- Sequences each access through issue, wait and response phases for a fixed-latency memory, and stalls the CPU while its request is pending.
- Sits between the datapath's memory-address/data registers and the memory macro.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MEM_LAT, 2, cycles from mem_en (read) to valid mem_rdata; legal range 1..7
DBG_PRIORITY, 0, 0 = round-robin between requesters; 1 = dbg always wins ties

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  read data, valid with cpu_ack
cpu_ack  out  1  one-cycle completion pulse
cpu_stall  out  1  cpu_req & ~cpu_ack (combinational); freezes Control
dbg_req / dbg_we / dbg_addr / dbg_wdata  in  1/1/ADDR_W/DATA_W  same protocol as CPU side
dbg_rdata  out  DATA_W  debug read data
dbg_ack  out  1  debug completion pulse
mem_en  out  1  memory access strobe (registered)
mem_we  out  1  memory write enable (registered)
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_rdata  in  DATA_W  memory read data
arb_state  out  3  current FSM state, for debug/verification

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE; all outputs 0 (cpu_stall follows cpu_req); last_grant=DBG, so the CPU wins the first tie. Reset mid-access aborts it: mem_en drops immediately, no ack is issued.
- States (arb_state encoding): IDLE=0, ISSUE=1, WAIT=2, RESP=3.
- IDLE: if any req is high, pick the winner, latch we/addr/wdata and the winner ID, then go to ISSUE. If no req, stay.
- Winner rules:
  - only one req: that requester wins.
  - both req, DBG_PRIORITY=0: the requester not equal to last_grant wins.
  - both req, DBG_PRIORITY=1: dbg wins.
  - last_grant updates on entry to ISSUE.
- ISSUE (1 cycle): mem_en=1; mem_we, mem_addr and mem_wdata are driven from the latches. Counter loads MEM_LAT-1.
  - Write: go to RESP.
  - Read: if MEM_LAT=1, go to RESP; else go to WAIT.
- WAIT: mem_en=0; decrement the counter; go to RESP when the counter reaches 1.
- RESP (1 cycle): for a read, capture mem_rdata into the winner's rdata register. Pulse the winner's ack=1 with rdata valid in that same cycle. Next state is IDLE.
- Latency from req sampled in IDLE (cycle T):
  - ack at T+2 for a write.
  - ack at T+1+MEM_LAT+1 for a read.
  - One IDLE cycle separates accesses.
- rdata holds its last value until the next read by the same requester; the non-winner's rdata never changes.
- Requester drops req before ack (protocol violation): the access completes and the ack pulse is still generated; the bench flags it as an error.
- A req arriving while another access is in flight waits; its stall remains high. No request is lost.
- Address/data changes after IDLE sampling are ignored until the next access.

Decomposition:
- Shared package:
  - state encodings IDLE/ISSUE/WAIT/RESP
  - requester IDs CPU=0, DBG=1
  - MEM_LAT bounds
- One natural sub-module: mem_lat_counter (3-bit down-counter with load and done flag).
- Winner selection stays inline.

Test Plan:
1. Reset low mid-read (state WAIT) -> arb_state=0, mem_en=0 the same cycle, no cpu_ack; after release, the first tie goes to the CPU.
2. CPU write only, addr=16'h0040, wdata=16'hBEEF -> mem_en=1, mem_we=1, addr=16'h0040 in cycle T+1; cpu_ack at T+2; cpu_stall high from T until the ack cycle.
3. CPU read, MEM_LAT=2, memory returns 16'h1234 -> arb_state sequence 0,1,2,3; cpu_ack at T+4 with cpu_rdata=16'h1234; dbg_rdata unchanged.
4. cpu_req and dbg_req both high continuously, DBG_PRIORITY=0 -> grants alternate CPU, DBG, CPU, DBG; each ack arrives exactly once per access.
5. Same as scenario 4 with DBG_PRIORITY=1 -> dbg wins every tie; the CPU is granted only after dbg_req drops.
6. MEM_LAT=1 read -> WAIT is skipped (states 0,1,3); ack at T+3 with correct data.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encodings, requester IDs and latency bounds for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3
  } arb_state_e;
  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 7;
  // Counter preload for a given read latency, clamped to the supported range.
  function automatic logic [2:0] lat_init(input int lat);
    return (lat < MEM_LAT_MIN) ? 3'd0 : (lat > MEM_LAT_MAX) ? 3'(MEM_LAT_MAX - 1) : 3'(lat - 1);
  endfunction
endpackage

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: 3-bit down-counter with synchronous load and a done flag at count 1
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   load_i         : load load_val_i (has priority over dec_i)
//   load_val_i     : preload value
//   dec_i          : decrement, saturating at 0
//   done_o         : count equals 1 (last wait cycle)
module mem_lat_counter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  input  logic       dec_i,
  output logic       done_o
);
  logic [2:0] cnt_q, cnt_d;
  assign cnt_d  = load_i ? load_val_i : (dec_i && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
  assign done_o = cnt_q == 3'd1;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= 3'd0;
    else         cnt_q <= cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between the CPU and the debug/boot port
//   clk_i, rst_ni                         : clock, asynchronous active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i         : CPU request, held until cpu_ack_o
//   cpu_rdata_o, cpu_ack_o, cpu_stall_o   : CPU read data, completion pulse, stall
//   dbg_req_i/we_i/addr_i/wdata_i         : debug request, same protocol
//   dbg_rdata_o, dbg_ack_o                : debug read data, completion pulse
//   mem_en_o/we_o/addr_o/wdata_o          : registered memory strobe, write enable, address, data
//   mem_rdata_i                           : memory read data, valid MEM_LAT cycles after mem_en_o
//   arb_state_o                           : current FSM state
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MEM_LAT      = 2,
  parameter int DBG_PRIORITY = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_ack_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [2:0]        arb_state_o
);
  arb_state_e        st_q, st_d;
  req_id_e           win_q, last_q, sel;
  logic              we_q, mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, cpu_rdata_q, dbg_rdata_q;
  logic [1:0]        rd_ack_q;
  logic              cpu_pend, dbg_pend, take, sel_we, resp_rd, wr_ack;
  logic              lat_load, lat_dec, lat_done;
  // A read ack is pulsed in the IDLE cycle after RESP; the acked requester
  // still holds req then, so it must not be mistaken for a new request.
  assign cpu_pend = cpu_req_i & ~rd_ack_q[0];
  assign dbg_pend = dbg_req_i & ~rd_ack_q[1];
  assign sel      = (cpu_pend && dbg_pend)
                    ? ((DBG_PRIORITY != 0 || last_q == REQ_CPU) ? REQ_DBG : REQ_CPU)
                    : (dbg_pend ? REQ_DBG : REQ_CPU);
  assign take     = (st_q == IDLE) && (cpu_pend || dbg_pend);
  assign sel_we   = (sel == REQ_DBG) ? dbg_we_i : cpu_we_i;
  assign resp_rd  = (st_q == RESP) && !we_q;
  assign wr_ack   = (st_q == RESP) && we_q;
  always_comb begin
    st_d     = st_q;
    lat_load = 1'b0;
    lat_dec  = 1'b0;
    case (st_q)
      IDLE:  st_d = take ? ISSUE : IDLE;
      ISSUE: begin
        lat_load = 1'b1;
        st_d     = (we_q || MEM_LAT == 1) ? RESP : WAIT;
      end
      WAIT:  begin
        lat_dec = 1'b1;
        st_d    = lat_done ? RESP : WAIT;
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      st_q        <= IDLE;
      win_q       <= REQ_CPU;
      last_q      <= REQ_DBG;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      rd_ack_q    <= 2'b00;
    end else begin
      st_q     <= st_d;
      mem_en_q <= take;
      mem_we_q <= take & sel_we;
      rd_ack_q <= {resp_rd && win_q == REQ_DBG, resp_rd && win_q == REQ_CPU};
      if (take) begin
        win_q   <= sel;
        last_q  <= sel;
        we_q    <= sel_we;
        addr_q  <= (sel == REQ_DBG) ? dbg_addr_i : cpu_addr_i;
        wdata_q <= (sel == REQ_DBG) ? dbg_wdata_i : cpu_wdata_i;
      end
      if (resp_rd && win_q == REQ_CPU) cpu_rdata_q <= mem_rdata_i;
      if (resp_rd && win_q == REQ_DBG) dbg_rdata_q <= mem_rdata_i;
    end
  mem_lat_counter u_lat (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (lat_load),
    .load_val_i (lat_init(MEM_LAT)),
    .dec_i      (lat_dec),
    .done_o     (lat_done)
  );
  assign cpu_ack_o   = rd_ack_q[0] | (wr_ack && win_q == REQ_CPU);
  assign dbg_ack_o   = rd_ack_q[1] | (wr_ack && win_q == REQ_DBG);
  assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dbg_rdata_o = dbg_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign arb_state_o = st_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of three arbiter configurations driven by shared stimulus
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, rd_word;
  logic        cpu_ack[3], cpu_stall[3], dbg_ack[3], mem_en[3], mem_we[3];
  logic [15:0] cpu_rdata[3], dbg_rdata[3], mem_addr[3], mem_wdata[3], mem_rdata[3];
  logic [2:0]  arb_state[3];
  logic [6:0]  sh[3];
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  // Memory model: read data appears exactly MEM_LAT cycles after a read strobe, else garbage.
  initial for (int i = 0; i < 3; i++) sh[i] = '0;
  always @(posedge clk) for (int i = 0; i < 3; i++) sh[i] <= {sh[i][5:0], mem_en[i] & ~mem_we[i]};
  assign mem_rdata[0] = sh[0][1] ? rd_word : 16'hDEAD;
  assign mem_rdata[1] = sh[1][1] ? rd_word : 16'hDEAD;
  assign mem_rdata[2] = sh[2][0] ? rd_word : 16'hDEAD;
  // u_a: MEM_LAT=2 round-robin; u_b: MEM_LAT=2 debug priority; u_c: MEM_LAT=1 round-robin
  mem_port_arbiter #(.MEM_LAT(2), .DBG_PRIORITY(0)) u_a (
    .clk_i(clk), .rst_ni(rst_ni),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata[0]), .cpu_ack_o(cpu_ack[0]), .cpu_stall_o(cpu_stall[0]),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_rdata_o(dbg_rdata[0]), .dbg_ack_o(dbg_ack[0]),
    .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]),
    .mem_rdata_i(mem_rdata[0]), .arb_state_o(arb_state[0]));
  mem_port_arbiter #(.MEM_LAT(2), .DBG_PRIORITY(1)) u_b (
    .clk_i(clk), .rst_ni(rst_ni),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata[1]), .cpu_ack_o(cpu_ack[1]), .cpu_stall_o(cpu_stall[1]),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_rdata_o(dbg_rdata[1]), .dbg_ack_o(dbg_ack[1]),
    .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]),
    .mem_rdata_i(mem_rdata[1]), .arb_state_o(arb_state[1]));
  mem_port_arbiter #(.MEM_LAT(1), .DBG_PRIORITY(0)) u_c (
    .clk_i(clk), .rst_ni(rst_ni),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata[2]), .cpu_ack_o(cpu_ack[2]), .cpu_stall_o(cpu_stall[2]),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_rdata_o(dbg_rdata[2]), .dbg_ack_o(dbg_ack[2]),
    .mem_en_o(mem_en[2]), .mem_we_o(mem_we[2]), .mem_addr_o(mem_addr[2]), .mem_wdata_o(mem_wdata[2]),
    .mem_rdata_i(mem_rdata[2]), .arb_state_o(arb_state[2]));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_ni = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; rd_word = 16'h1234;
    repeat (3) step();
    chk("rst_state", arb_state[0], 0);
    chk("rst_mem_en", mem_en[0], 0);
    chk("rst_ack", cpu_ack[0], 0);
    chk("rst_stall", cpu_stall[0], 1);
    chk("rst_addr", mem_addr[0], 0);
    chk("rst_rdata", cpu_rdata[0], 0);
    cpu_req = 1'b0; rst_ni = 1'b1;
    step();
    // CPU write: issue at T+1, ack at T+2
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'hBEEF;
    #1;
    chk("wr_T_stall", cpu_stall[0], 1);
    step();
    chk("wr_T1_state", arb_state[0], 1);
    chk("wr_T1_en", mem_en[0], 1);
    chk("wr_T1_we", mem_we[0], 1);
    chk("wr_T1_addr", mem_addr[0], 16'h0040);
    chk("wr_T1_wdata", mem_wdata[0], 16'hBEEF);
    chk("wr_T1_ack", cpu_ack[0], 0);
    chk("wr_T1_stall", cpu_stall[0], 1);
    step();
    chk("wr_T2_state", arb_state[0], 3);
    chk("wr_T2_ack", cpu_ack[0], 1);
    chk("wr_T2_stall", cpu_stall[0], 0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();
    chk("wr_T3_state", arb_state[0], 0);
    chk("wr_T3_ack", cpu_ack[0], 0);
    chk("wr_T3_en", mem_en[0], 0);
    // CPU read: u_a (MEM_LAT=2) states 0,1,2,3 ack T+4; u_c (MEM_LAT=1) states 0,1,3 ack T+3
    cpu_req = 1'b1; cpu_addr = 16'h0010;
    #1;
    chk("rd_T_state", arb_state[0], 0);
    step();
    chk("rd_T1_state", arb_state[0], 1);
    chk("rd_T1_en", mem_en[0], 1);
    chk("rd_T1_we", mem_we[0], 0);
    chk("lat1_T1_state", arb_state[2], 1);
    cpu_addr = 16'h9999;
    step();
    chk("rd_T2_state", arb_state[0], 2);
    chk("rd_T2_en", mem_en[0], 0);
    chk("rd_T2_addr_held", mem_addr[0], 16'h0010);
    chk("lat1_T2_state", arb_state[2], 3);
    chk("lat1_T2_ack", cpu_ack[2], 0);
    step();
    chk("rd_T3_state", arb_state[0], 3);
    chk("rd_T3_ack", cpu_ack[0], 0);
    chk("rd_T3_stall", cpu_stall[0], 1);
    chk("lat1_T3_state", arb_state[2], 0);
    chk("lat1_T3_ack", cpu_ack[2], 1);
    chk("lat1_T3_rdata", cpu_rdata[2], 16'h1234);
    step();
    chk("rd_T4_state", arb_state[0], 0);
    chk("rd_T4_ack", cpu_ack[0], 1);
    chk("rd_T4_rdata", cpu_rdata[0], 16'h1234);
    chk("rd_T4_dbg_rdata", dbg_rdata[0], 0);
    chk("lat1_T4_ack", cpu_ack[2], 0);
    cpu_req = 1'b0;
    step();
    chk("rd_T5_ack", cpu_ack[0], 0);
    chk("rd_T5_stall", cpu_stall[0], 0);
    chk("rd_T5_state", arb_state[0], 0);
    // Debug read: dbg_rdata updates, cpu_rdata keeps its old value
    rd_word = 16'h5A5A; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0030;
    step();
    chk("drd_T1_addr", mem_addr[0], 16'h0030);
    repeat (3) step();
    chk("drd_T4_ack", dbg_ack[0], 1);
    chk("drd_T4_cpu_ack", cpu_ack[0], 0);
    chk("drd_T4_rdata", dbg_rdata[0], 16'h5A5A);
    chk("drd_T4_cpu_rdata", cpu_rdata[0], 16'h1234);
    dbg_req = 1'b0;
    step();
    // Reset mid-read while u_a waits and u_c is in RESP: abort, no ack
    rd_word = 16'h7777; cpu_req = 1'b1; cpu_addr = 16'h0020;
    step();
    step();
    chk("abort_pre_state", arb_state[0], 2);
    rst_ni = 1'b0;
    #1;
    chk("abort_state", arb_state[0], 0);
    chk("abort_en", mem_en[0], 0);
    chk("abort_ack", cpu_ack[0], 0);
    step();
    chk("abort_ack_next", cpu_ack[0], 0);
    chk("abort_lat1_ack", cpu_ack[2], 0);
    chk("abort_rdata", cpu_rdata[0], 0);
    // Both requesting writes continuously: u_a alternates from CPU, u_b always dbg
    cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'h1111;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0200; dbg_wdata = 16'h2222;
    rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_addr", mem_addr[0], (k % 2 == 0) ? 32'h0100 : 32'h0200);
      chk("pri_addr", mem_addr[1], 16'h0200);
      step();
      chk("rr_cpu_ack", cpu_ack[0], (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_dbg_ack", dbg_ack[0], (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("pri_dbg_ack", dbg_ack[1], 1);
      chk("pri_cpu_ack", cpu_ack[1], 0);
      chk("pri_cpu_stall", cpu_stall[1], 1);
      step();
      chk("rr_idle_cpu_ack", cpu_ack[0], 0);
      chk("rr_idle_dbg_ack", dbg_ack[0], 0);
    end
    dbg_req = 1'b0;
    step();
    chk("pri_cpu_addr", mem_addr[1], 16'h0100);
    chk("pri_cpu_wdata", mem_wdata[1], 16'h1111);
    step();
    chk("pri_cpu_granted", cpu_ack[1], 1);
    cpu_req = 1'b0;
    step();
    chk("end_state", arb_state[1], 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
